pipe_hazard_ctrl: RTL and testbench

- Central sequencing unit for the 5-stage pipeline.
- Each cycle it decides the next-PC source, PC/IF-ID hold, and IF-ID/ID-EX flush.
- Arbitrates competing redirect events (exception, branch, interrupt, jump) and inserts load-use and jr-dependency stalls.
- Latches timer interrupts and injects them at a safe ID-stage slot. Sits beside the IF / IF_ID / ID_EX register modules and drives their control inputs.

---
 rtl/pipe_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: next-PC selection, stalls, flushes and irq injection for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int JR_MAX_STALL = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq,
    input  logic       ID_valid,
    input  logic       ID_PC_super,
    input  logic       ID_EXP,
    input  logic       ID_Jump_I,
    input  logic       ID_Jump_R,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       EX_MemRd,
    input  logic       EX_RegWr,
    input  logic [4:0] EX_WrReg,
    input  logic       MEM_MemRd,
    input  logic [4:0] MEM_WrReg,
    input  logic       EX_Branch_EN,
    output logic [2:0] PCSrc,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       IRQ_take,
    output logic       EXP_take,
    output logic       irq_pending
);
    localparam logic RUN = 1'b0;
    localparam logic STALL = 1'b1;
    localparam int CW = $clog2(JR_MAX_STALL + 1);
    logic          state_q, state_d;
    logic          irq_pending_q, irq_pending_d;
    logic [CW-1:0] jr_cnt_q, jr_cnt_d;
    logic          loaduse, jrdep, jr_ok;
    logic          r_br, r_exp, r_irq, r_stall, r_ji, r_jr;
    logic          p_exp, p_irq, p_stall, p_jmp;
    always_comb begin
        loaduse = EX_MemRd & (EX_WrReg != 5'd0) &
                  ((ID_UseRs & (EX_WrReg == ID_Rs)) | (ID_UseRt & (EX_WrReg == ID_Rt)));
        jrdep = ID_Jump_R & (ID_Rs != 5'd0) &
                ((EX_RegWr & (EX_WrReg == ID_Rs)) | (MEM_MemRd & (MEM_WrReg == ID_Rs)));
        jr_ok = jr_cnt_q < CW'(JR_MAX_STALL);
        // reset low forces every action off so outputs fall back to benign values at once
        r_br = reset & EX_Branch_EN;
        p_exp = reset & ~EX_Branch_EN;
        r_exp = p_exp & ID_EXP & ID_valid;
        p_irq = p_exp & ~r_exp;
        r_irq = p_irq & irq_pending_q & ID_valid & ~ID_PC_super & (state_q == RUN);
        p_stall = p_irq & ~r_irq;
        r_stall = p_stall & (loaduse | (jrdep & jr_ok));
        p_jmp = p_stall & ~r_stall;
        r_ji = p_jmp & ID_Jump_I;
        r_jr = p_jmp & ~ID_Jump_I & ID_Jump_R;
        PCSrc = r_br ? 3'b001 : r_exp ? 3'b101 : r_irq ? 3'b100 :
                r_ji ? 3'b010 : r_jr ? 3'b011 : 3'b000;
        PC_Write = ~r_stall;
        IFID_Write = ~r_stall;
        IFID_Flush = r_br | r_exp | r_irq | r_ji | r_jr;
        IDEX_Flush = r_br | r_stall;
        IRQ_take = r_irq;
        EXP_take = r_exp;
        irq_pending = irq_pending_q;
        state_d = r_stall ? STALL : RUN;
        irq_pending_d = r_irq ? 1'b0 : (irq & ~ID_PC_super) ? 1'b1 : irq_pending_q;
        jr_cnt_d = r_jr ? '0 : (r_stall & jrdep & jr_ok) ? jr_cnt_q + 1'b1 : jr_cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            irq_pending_q <= 1'b0;
            jr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            irq_pending_q <= irq_pending_d;
            jr_cnt_q <= jr_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus random traffic against a priority-table reference model
module tb_pipe_hazard_ctrl;
    localparam int JR_MAX = 2;
    logic       clk = 0;
    logic       reset, irq, ID_valid, ID_PC_super, ID_EXP, ID_Jump_I, ID_Jump_R;
    logic       ID_UseRs, ID_UseRt, EX_MemRd, EX_RegWr, MEM_MemRd, EX_Branch_EN;
    logic [4:0] ID_Rs, ID_Rt, EX_WrReg, MEM_WrReg;
    logic [2:0] PCSrc;
    logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, IRQ_take, EXP_take, irq_pending;
    int         n_tests = 0, n_fail = 0;
    int         m_pend = 0, m_stall = 0, m_cnt = 0;
    pipe_hazard_ctrl #(.JR_MAX_STALL(JR_MAX)) dut (
        .clk(clk), .reset(reset), .irq(irq), .ID_valid(ID_valid), .ID_PC_super(ID_PC_super),
        .ID_EXP(ID_EXP), .ID_Jump_I(ID_Jump_I), .ID_Jump_R(ID_Jump_R), .ID_UseRs(ID_UseRs),
        .ID_UseRt(ID_UseRt), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_MemRd(EX_MemRd),
        .EX_RegWr(EX_RegWr), .EX_WrReg(EX_WrReg), .MEM_MemRd(MEM_MemRd),
        .MEM_WrReg(MEM_WrReg), .EX_Branch_EN(EX_Branch_EN), .PCSrc(PCSrc),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Flush(IDEX_Flush), .IRQ_take(IRQ_take), .EXP_take(EXP_take),
        .irq_pending(irq_pending)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic clr();
        {irq, ID_valid, ID_PC_super, ID_EXP, ID_Jump_I, ID_Jump_R, ID_UseRs, ID_UseRt} = '0;
        {EX_MemRd, EX_RegWr, MEM_MemRd, EX_Branch_EN} = '0;
        {ID_Rs, ID_Rt, EX_WrReg, MEM_WrReg} = '0;
    endtask
    // inputs are already applied just after a negedge; check mid-phase, then advance the model at posedge
    task automatic tick();
        bit lu, jd;
        int act;
        logic [2:0] e_pc;
        #1;
        lu = EX_MemRd && EX_WrReg != 0 &&
             ((ID_UseRs && EX_WrReg == ID_Rs) || (ID_UseRt && EX_WrReg == ID_Rt));
        jd = ID_Jump_R && ID_Rs != 0 &&
             ((EX_RegWr && EX_WrReg == ID_Rs) || (MEM_MemRd && MEM_WrReg == ID_Rs));
        if (!reset) begin
            act = 7; m_pend = 0; m_stall = 0; m_cnt = 0;
        end
        else if (EX_Branch_EN) act = 1;
        else if (ID_EXP && ID_valid) act = 2;
        else if (m_pend != 0 && ID_valid && !ID_PC_super && m_stall == 0) act = 3;
        else if (lu || (jd && m_cnt < JR_MAX)) act = 4;
        else if (ID_Jump_I) act = 5;
        else if (ID_Jump_R) act = 6;
        else act = 7;
        case (act)
            1: e_pc = 3'b001;
            2: e_pc = 3'b101;
            3: e_pc = 3'b100;
            5: e_pc = 3'b010;
            6: e_pc = 3'b011;
            default: e_pc = 3'b000;
        endcase
        check("pcsrc", 32'(PCSrc), 32'(e_pc));
        check("hold", 32'({PC_Write, IFID_Write}), (act == 4) ? 32'd0 : 32'd3);
        check("flush", 32'({IFID_Flush, IDEX_Flush}),
              32'({act == 1 || act == 2 || act == 3 || act == 5 || act == 6, act == 1 || act == 4}));
        check("take", 32'({IRQ_take, EXP_take}), 32'({act == 3, act == 2}));
        check("pend", 32'(irq_pending), 32'(m_pend));
        @(posedge clk);
        if (reset) begin
            if (act == 3) m_pend = 0;
            else if (irq && !ID_PC_super) m_pend = 1;
            if (act == 4 && jd && m_cnt < JR_MAX) m_cnt++;
            else if (act == 6) m_cnt = 0;
            m_stall = (act == 4) ? 1 : 0;
        end
        @(negedge clk);
    endtask
    initial begin
        clr();
        reset = 0;
        @(negedge clk);
        tick();
        reset = 1;
        tick();
        EX_MemRd = 1; EX_WrReg = 8; ID_UseRs = 1; ID_Rs = 8; ID_valid = 1;
        tick();
        clr(); ID_valid = 1;
        tick();
        EX_RegWr = 1; EX_WrReg = 31; ID_Jump_R = 1; ID_Rs = 31; ID_valid = 1;
        tick();
        EX_RegWr = 0;
        tick();
        EX_RegWr = 1; MEM_MemRd = 1; MEM_WrReg = 31;
        repeat (3) tick();
        clr(); irq = 1; ID_valid = 1; ID_EXP = 1;
        tick();
        irq = 0; ID_EXP = 0;
        repeat (2) tick();
        clr(); ID_PC_super = 1; irq = 1; ID_valid = 1;
        repeat (10) tick();
        clr(); irq = 1;
        tick();
        irq = 0; EX_Branch_EN = 1; ID_Jump_I = 1; ID_valid = 1;
        tick();
        EX_Branch_EN = 0; ID_Jump_I = 0;
        tick();
        EX_MemRd = 1; EX_WrReg = 5; ID_UseRt = 1; ID_Rt = 5; ID_valid = 1; irq = 1;
        tick();
        irq = 0; reset = 0;
        tick();
        reset = 1;
        tick();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) != 0);
            irq = ($urandom_range(0, 7) == 0);
            ID_valid = ($urandom_range(0, 3) != 0);
            ID_PC_super = ($urandom_range(0, 5) == 0);
            ID_EXP = ($urandom_range(0, 15) == 0);
            ID_Jump_I = ($urandom_range(0, 7) == 0);
            ID_Jump_R = ($urandom_range(0, 2) == 0);
            ID_UseRs = $urandom_range(0, 1);
            ID_UseRt = $urandom_range(0, 1);
            ID_Rs = 5'($urandom_range(0, 3));
            ID_Rt = 5'($urandom_range(0, 3));
            EX_MemRd = ($urandom_range(0, 2) == 0);
            EX_RegWr = $urandom_range(0, 1);
            EX_WrReg = 5'($urandom_range(0, 3));
            MEM_MemRd = ($urandom_range(0, 2) == 0);
            MEM_WrReg = 5'($urandom_range(0, 3));
            EX_Branch_EN = ($urandom_range(0, 9) == 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
